// File: rtl/uart_rx_cfg.sv
// Configurable serial receiver: oversampled 3-sample majority voting, optional parity,
// 1-2 stop bits, valid/ready output with framing, parity, overrun and break reporting.
module uart_rx_cfg #(
   parameter int ClkFrequency = 24000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 16,
   parameter int DataBits     = 8,
   parameter int Parity       = 0,
   parameter int StopBits     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                RxD,
   output logic [DataBits-1:0] RxD_data,
   output logic                RxD_valid,
   input  logic                RxD_ready,
   output logic                RxD_perr,
   output logic                RxD_ferr,
   output logic                RxD_overrun,
   output logic                RxD_break,
   output logic                RxD_busy
);
   localparam int Divisor = (ClkFrequency + Baud*Oversampling/2) / (Baud*Oversampling);
   localparam int DivW    = (Divisor > 1) ? $clog2(Divisor) : 1;
   localparam int PhW     = $clog2(Oversampling);
   localparam int HiW     = PhW + 1;
   localparam int Half    = Oversampling / 2;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK_WAIT
   } state_t;

   state_t              r_state, w_next;
   logic [1:0]          r_sync;
   logic                r_rx_prev;
   logic [DivW-1:0]     r_tick_cnt;
   logic [PhW-1:0]      r_phase;
   logic [1:0]          r_samp;
   logic [3:0]          r_bit_idx;
   logic [DataBits-1:0] r_shift;
   logic                r_par_err, r_frm_err, r_any_one;
   logic [HiW-1:0]      r_hi_cnt;

   logic w_rx, w_fall, w_start, w_tick, w_decide, w_bit;
   logic w_last_data, w_last_stop, w_hi_done, w_par_calc;

   assign w_rx        = r_sync[1];
   assign w_fall      = r_rx_prev & ~w_rx;
   assign w_start     = (r_state == S_IDLE) && w_fall;
   assign w_tick      = (r_tick_cnt == DivW'(Divisor - 1));
   assign w_decide    = w_tick && (r_phase == PhW'(Half + 1));
   // The third vote is the live sample taken on the decision tick itself.
   assign w_bit       = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
   assign w_last_data = (r_bit_idx == 4'(DataBits - 1));
   assign w_last_stop = (r_bit_idx == 4'(StopBits - 1));
   assign w_hi_done   = w_tick && w_rx && (r_hi_cnt == HiW'(Oversampling - 1));
   assign w_par_calc  = ^{r_shift, w_bit};
   assign RxD_busy    = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_fall) w_next = S_START;
         S_START:      if (w_decide) w_next = w_bit ? S_IDLE : S_DATA;
         S_DATA:       if (w_decide && w_last_data) w_next = (Parity != 0) ? S_PARITY : S_STOP;
         S_PARITY:     if (w_decide) w_next = S_STOP;
         S_STOP:       if (w_decide && w_last_stop) w_next = S_DONE;
         S_DONE:       w_next = r_any_one ? S_IDLE : S_BREAK_WAIT;
         S_BREAK_WAIT: if (w_hi_done) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: synchroniser resets to the idle line level so release never fakes a start edge.
         r_sync      <= 2'b11;
         r_rx_prev   <= 1'b1;
         r_tick_cnt  <= '0;
         r_phase     <= '0;
         r_samp      <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_par_err   <= 1'b0;
         r_frm_err   <= 1'b0;
         r_any_one   <= 1'b0;
         r_hi_cnt    <= '0;
         RxD_data    <= '0;
         RxD_valid   <= 1'b0;
         RxD_perr    <= 1'b0;
         RxD_ferr    <= 1'b0;
         RxD_overrun <= 1'b0;
         RxD_break   <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], RxD};
         r_rx_prev   <= w_rx;
         RxD_overrun <= 1'b0;
         RxD_break   <= 1'b0;

         if (w_start) begin
            r_tick_cnt <= '0;
            r_phase    <= '0;
            r_bit_idx  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_any_one  <= 1'b0;
         end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) r_phase <= r_phase + 1'b1;
         end

         if (w_tick && r_phase == PhW'(Half - 1)) r_samp[0] <= w_rx;
         if (w_tick && r_phase == PhW'(Half))     r_samp[1] <= w_rx;

         if (w_decide) begin
            case (r_state)
               S_DATA: begin
                  r_shift   <= {w_bit, r_shift[DataBits-1:1]};
                  r_any_one <= r_any_one | w_bit;
                  r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
               end
               S_PARITY: begin
                  r_par_err <= (Parity == 2) ? ~w_par_calc : w_par_calc;
                  r_any_one <= r_any_one | w_bit;
               end
               S_STOP: begin
                  if (!w_bit) r_frm_err <= 1'b1;
                  r_any_one <= r_any_one | w_bit;
                  r_bit_idx <= r_bit_idx + 4'd1;
               end
               default: ;
            endcase
         end

         if (r_state != S_BREAK_WAIT || !w_rx) r_hi_cnt <= '0;
         else if (w_tick)                      r_hi_cnt <= r_hi_cnt + 1'b1;

         if (RxD_valid && RxD_ready) RxD_valid <= 1'b0;

         // A frame completing in the acceptance cycle replaces the word instead of overrunning.
         if (r_state == S_DONE) begin
            if (!r_any_one) begin
               RxD_break <= 1'b1;
            end else if (!RxD_valid || RxD_ready) begin
               RxD_data  <= r_shift;
               RxD_perr  <= r_par_err;
               RxD_ferr  <= r_frm_err;
               RxD_valid <= 1'b1;
            end else begin
               RxD_overrun <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver configurations, one serial line each,
// 32 clk per bit (Divisor = 2, Oversampling = 16).
module tb_uart_rx_cfg;
   localparam int Clk    = 32000000;
   localparam int Bd     = 1000000;
   localparam int Os     = 16;
   localparam int BitClk = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] rxd = 4'hF;
   logic [3:0] rdy = 4'hF;
   wire  [3:0] vld, perr, ferr, ovr, brk, bsy;
   wire  [7:0] d0, d1, d2;
   wire  [4:0] d3;
   logic [7:0] dat [4];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_start = 0;

   int         acc_cnt [4];
   int         brk_cnt [4];
   int         ovr_cnt [4];
   int         rise_cyc [4];
   logic [7:0] acc_data [4];
   bit         acc_perr [4];
   bit         acc_ferr [4];
   bit         v_prev [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign dat[0] = d0;
   assign dat[1] = d1;
   assign dat[2] = d2;
   assign dat[3] = {3'b000, d3};

   uart_rx_cfg #(.ClkFrequency(Clk), .Baud(Bd), .Oversampling(Os), .DataBits(8), .Parity(0), .StopBits(1)) u_8n1 (
      .clk(clk), .rst(rst), .RxD(rxd[0]), .RxD_data(d0), .RxD_valid(vld[0]), .RxD_ready(rdy[0]),
      .RxD_perr(perr[0]), .RxD_ferr(ferr[0]), .RxD_overrun(ovr[0]), .RxD_break(brk[0]), .RxD_busy(bsy[0]));
   uart_rx_cfg #(.ClkFrequency(Clk), .Baud(Bd), .Oversampling(Os), .DataBits(8), .Parity(1), .StopBits(1)) u_even (
      .clk(clk), .rst(rst), .RxD(rxd[1]), .RxD_data(d1), .RxD_valid(vld[1]), .RxD_ready(rdy[1]),
      .RxD_perr(perr[1]), .RxD_ferr(ferr[1]), .RxD_overrun(ovr[1]), .RxD_break(brk[1]), .RxD_busy(bsy[1]));
   uart_rx_cfg #(.ClkFrequency(Clk), .Baud(Bd), .Oversampling(Os), .DataBits(8), .Parity(2), .StopBits(1)) u_odd (
      .clk(clk), .rst(rst), .RxD(rxd[2]), .RxD_data(d2), .RxD_valid(vld[2]), .RxD_ready(rdy[2]),
      .RxD_perr(perr[2]), .RxD_ferr(ferr[2]), .RxD_overrun(ovr[2]), .RxD_break(brk[2]), .RxD_busy(bsy[2]));
   uart_rx_cfg #(.ClkFrequency(Clk), .Baud(Bd), .Oversampling(Os), .DataBits(5), .Parity(0), .StopBits(2)) u_5n2 (
      .clk(clk), .rst(rst), .RxD(rxd[3]), .RxD_data(d3), .RxD_valid(vld[3]), .RxD_ready(rdy[3]),
      .RxD_perr(perr[3]), .RxD_ferr(ferr[3]), .RxD_overrun(ovr[3]), .RxD_break(brk[3]), .RxD_busy(bsy[3]));

   // Event recorder, sampled just after the falling edge so negedge-driven inputs are settled.
   always @(negedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (vld[i] && rdy[i]) begin
            acc_cnt[i]  <= acc_cnt[i] + 1;
            acc_data[i] <= dat[i];
            acc_perr[i] <= perr[i];
            acc_ferr[i] <= ferr[i];
         end
         if (vld[i] && !v_prev[i]) rise_cyc[i] <= cyc;
         if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
         if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
         v_prev[i] <= vld[i];
      end
   end

   task automatic drive_bit(input int ch, input logic b, input bit spike);
      if (spike) begin
         rxd[ch] = b;  repeat (18) @(negedge clk);
         rxd[ch] = ~b; repeat (2) @(negedge clk);
         rxd[ch] = b;  repeat (12) @(negedge clk);
      end else begin
         rxd[ch] = b;  repeat (BitClk) @(negedge clk);
      end
   endtask

   task automatic send_frame(input int ch, input logic [8:0] d, input int nbits, input bit has_par,
                             input logic par_bit, input int nstop, input logic [1:0] stops,
                             input int spike_idx);
      t_start = cyc;
      drive_bit(ch, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(ch, d[i], i == spike_idx);
      if (has_par) drive_bit(ch, par_bit, 1'b0);
      for (int i = 0; i < nstop; i++) drive_bit(ch, stops[i], 1'b0);
      rxd[ch] = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n * BitClk) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({vld[i], perr[i], ferr[i], ovr[i], brk[i], bsy[i]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags ch%0d: got %b, expected 000000", i,
                     {vld[i], perr[i], ferr[i], ovr[i], brk[i], bsy[i]});
         end
         checks++;
         if (dat[i] !== 8'h00) begin
            errors++; $display("FAIL reset_data ch%0d: got %h, expected 00", i, dat[i]);
         end
      end
      rst = 1'b0;
      idle_bits(2);
   endtask

   task automatic test_basic;
      int a;
      a = acc_cnt[0];
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[0] - a !== 1) begin errors++; $display("FAIL basic_count: got %0d, expected 1", acc_cnt[0] - a); end
      checks++;
      if (acc_data[0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h, expected a5", acc_data[0]); end
      checks++;
      if (acc_perr[0] !== 1'b0 || acc_ferr[0] !== 1'b0) begin
         errors++; $display("FAIL basic_flags: got perr=%b ferr=%b, expected 0 0", acc_perr[0], acc_ferr[0]);
      end
      checks++;
      if (rise_cyc[0] - t_start !== 312) begin
         errors++; $display("FAIL basic_latency: got %0d clk, expected 312", rise_cyc[0] - t_start);
      end
   endtask

   task automatic test_parity;
      int a;
      a = acc_cnt[1];
      send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[1] - a !== 1 || acc_data[1] !== 8'h03) begin
         errors++; $display("FAIL even_p1_word: got n=%0d data=%h, expected n=1 data=03", acc_cnt[1] - a, acc_data[1]);
      end
      checks++;
      if (acc_perr[1] !== 1'b1) begin errors++; $display("FAIL even_p1_perr: got %b, expected 1", acc_perr[1]); end
      send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[1] - a !== 2) begin errors++; $display("FAIL even_p0_count: got %0d, expected 2", acc_cnt[1] - a); end
      checks++;
      if (acc_perr[1] !== 1'b0) begin errors++; $display("FAIL even_p0_perr: got %b, expected 0", acc_perr[1]); end
      a = acc_cnt[2];
      send_frame(2, 9'h003, 8, 1'b1, 1'b0, 1, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[2] - a !== 1 || acc_data[2] !== 8'h03) begin
         errors++; $display("FAIL odd_p0_word: got n=%0d data=%h, expected n=1 data=03", acc_cnt[2] - a, acc_data[2]);
      end
      checks++;
      if (acc_perr[2] !== 1'b1) begin errors++; $display("FAIL odd_p0_perr: got %b, expected 1", acc_perr[2]); end
   endtask

   task automatic test_framing_break;
      int a, b;
      a = acc_cnt[0];
      b = brk_cnt[0];
      send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b00, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[0] - a !== 1 || acc_data[0] !== 8'h5A) begin
         errors++; $display("FAIL ferr_word: got n=%0d data=%h, expected n=1 data=5a", acc_cnt[0] - a, acc_data[0]);
      end
      checks++;
      if (acc_ferr[0] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b, expected 1", acc_ferr[0]); end
      a = acc_cnt[0];
      rxd[0] = 1'b0;
      repeat (12 * BitClk) @(negedge clk);
      checks++;
      if (brk_cnt[0] - b !== 1) begin errors++; $display("FAIL break_pulse: got %0d, expected 1", brk_cnt[0] - b); end
      checks++;
      if (acc_cnt[0] - a !== 0) begin errors++; $display("FAIL break_noword: got %0d, expected 0", acc_cnt[0] - a); end
      checks++;
      if (bsy[0] !== 1'b1) begin errors++; $display("FAIL break_wait_busy: got %b, expected 1", bsy[0]); end
      rxd[0] = 1'b1;
      idle_bits(2);
      checks++;
      if (bsy[0] !== 1'b0) begin errors++; $display("FAIL break_exit: got busy=%b, expected 0", bsy[0]); end
      send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[0] - a !== 1 || acc_data[0] !== 8'h11 || acc_ferr[0] !== 1'b0) begin
         errors++; $display("FAIL after_break: got n=%0d data=%h ferr=%b, expected n=1 data=11 ferr=0",
                            acc_cnt[0] - a, acc_data[0], acc_ferr[0]);
      end
   endtask

   task automatic test_overrun;
      int a, o;
      rdy[0] = 1'b0;
      a = acc_cnt[0];
      o = ovr_cnt[0];
      send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 2'b01, -1);
      idle_bits(1);
      checks++;
      if (vld[0] !== 1'b1 || d0 !== 8'h12) begin
         errors++; $display("FAIL hold_first: got valid=%b data=%h, expected 1 12", vld[0], d0);
      end
      checks++;
      if (ovr_cnt[0] - o !== 0) begin errors++; $display("FAIL early_overrun: got %0d, expected 0", ovr_cnt[0] - o); end
      send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1, 2'b01, -1);
      idle_bits(1);
      checks++;
      if (vld[0] !== 1'b1 || d0 !== 8'h12) begin
         errors++; $display("FAIL hold_after_overrun: got valid=%b data=%h, expected 1 12", vld[0], d0);
      end
      checks++;
      if (ovr_cnt[0] - o !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d, expected 1", ovr_cnt[0] - o); end
      rdy[0] = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (vld[0] !== 1'b0) begin errors++; $display("FAIL accept_drop: got valid=%b, expected 0", vld[0]); end
      idle_bits(2);
      checks++;
      if (acc_cnt[0] - a !== 1 || acc_data[0] !== 8'h12) begin
         errors++; $display("FAIL overrun_delivery: got n=%0d data=%h, expected n=1 data=12", acc_cnt[0] - a, acc_data[0]);
      end
   endtask

   task automatic test_glitch;
      int a;
      a = acc_cnt[0];
      rxd[0] = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bsy[0] !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy=%b, expected 1", bsy[0]); end
      repeat (5) @(negedge clk);
      rxd[0] = 1'b1;
      idle_bits(2);
      checks++;
      if (bsy[0] !== 1'b0 || acc_cnt[0] - a !== 0) begin
         errors++; $display("FAIL glitch_reject: got busy=%b n=%0d, expected 0 0", bsy[0], acc_cnt[0] - a);
      end
      send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b01, 3);
      idle_bits(2);
      checks++;
      if (acc_cnt[0] - a !== 1 || acc_data[0] !== 8'hFF) begin
         errors++; $display("FAIL spike_mask: got n=%0d data=%h, expected n=1 data=ff", acc_cnt[0] - a, acc_data[0]);
      end
   endtask

   task automatic test_5bit_reset;
      int a;
      a = acc_cnt[3];
      send_frame(3, 9'h015, 5, 1'b0, 1'b0, 2, 2'b11, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[3] - a !== 1 || acc_data[3] !== 8'h15 || acc_ferr[3] !== 1'b0) begin
         errors++; $display("FAIL w5_word: got n=%0d data=%h ferr=%b, expected n=1 data=15 ferr=0",
                            acc_cnt[3] - a, acc_data[3], acc_ferr[3]);
      end
      send_frame(3, 9'h015, 5, 1'b0, 1'b0, 2, 2'b01, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[3] - a !== 2 || acc_ferr[3] !== 1'b1) begin
         errors++; $display("FAIL w5_stop2_ferr: got n=%0d ferr=%b, expected n=2 ferr=1", acc_cnt[3] - a, acc_ferr[3]);
      end
      drive_bit(3, 1'b0, 1'b0);
      drive_bit(3, 1'b0, 1'b0);
      drive_bit(3, 1'b1, 1'b0);
      checks++;
      if (bsy[3] !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b, expected 1", bsy[3]); end
      rst = 1'b1;
      #1;
      checks++;
      if ({vld, perr, ferr, ovr, brk, bsy} !== 24'h0 || d3 !== 5'h00) begin
         errors++; $display("FAIL async_reset: got flags=%h data=%h, expected 0 0", {vld, perr, ferr, ovr, brk, bsy}, d3);
      end
      @(negedge clk);
      rxd[3] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
      a = acc_cnt[3];
      send_frame(3, 9'h00A, 5, 1'b0, 1'b0, 2, 2'b11, -1);
      idle_bits(2);
      checks++;
      if (acc_cnt[3] - a !== 1 || acc_data[3] !== 8'h0A || acc_ferr[3] !== 1'b0) begin
         errors++; $display("FAIL post_reset_word: got n=%0d data=%h ferr=%b, expected n=1 data=0a ferr=0",
                            acc_cnt[3] - a, acc_data[3], acc_ferr[3]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_framing_break();
      test_overrun();
      test_glitch();
      test_5bit_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised serial receiver. It is the next generation of the fixed 8N1 RS-232 receiver and adds configurable data width, parity, stop bits and oversampling. It uses 3-sample majority voting and a valid/ready output handshake, and it flags framing, parity, overrun and break conditions. It sits between the board RxD pin and the command/packet logic. It has one clock and one reset.

Parameters:
- ClkFrequency, 24000000, system clock in Hz.
- Baud, 115200, bit rate.
- Oversampling, 16, samples per bit; power of 2 and at least 8.
- DataBits, 8, data bits per frame; legal range 5..9.
- Parity, 0, 0 = none, 1 = even, 2 = odd.
- StopBits, 1, number of stop bits checked; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- RxD  in  1  serial line, idle high, asynchronous to clk.
- RxD_data  out  DataBits  received word, LSB = first bit on line.
- RxD_valid  out  1  RxD_data, RxD_perr and RxD_ferr are valid; held until accepted.
- RxD_ready  in  1  consumer accepts the word when RxD_valid && RxD_ready at a clk edge.
- RxD_perr  out  1  parity error for the held word; always 0 when Parity = 0.
- RxD_ferr  out  1  framing error (a stop bit sampled low) for the held word.
- RxD_overrun  out  1  one-cycle pulse: a completed frame was dropped.
- RxD_break  out  1  one-cycle pulse: break condition detected.
- RxD_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset and timing base
  - Reset is asynchronous and active-high. All outputs go to 0 and the state goes to IDLE.
  - The sync flops reset to 1. The tick counter and bit counters reset to 0.
  - Reset mid-frame abandons the frame. No pulse and no data are produced.
- Sampling and tick generation
  - RxD passes through a 2-flop synchroniser clocked every clk. All later logic uses the synchronised bit only.
  - Divisor = (ClkFrequency + Baud*Oversampling/2) / (Baud*Oversampling), integer arithmetic, and must be at least 1.
  - A tick counter runs 0..Divisor-1 and produces a one-clk tick at Divisor-1. It is cleared on start detection so bit phase aligns to the falling edge.
  - Phase counter: log2(Oversampling) bits, incremented per tick, wraps to 0. Its value 0 marks the first tick after the edge.
  - Each bit is decided by majority of the samples at phases O/2-1, O/2 and O/2+1, where O = Oversampling. The decision is taken on the O/2+1 tick.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; plus BREAK_WAIT.
  - IDLE: a synchronised 1->0 transition goes to START, clears the tick and phase counters, and clears the bit index.
  - START: at the decision tick, a majority 1 is a glitch; go to IDLE with no output. A majority 0 goes to DATA.
  - DATA: one decision per bit period, shifted in LSB first. After DataBits bits go to PARITY if Parity != 0, else to STOP.
  - PARITY: even mode sets perr if XOR(data, parity bit) = 1. Odd mode sets perr if that XOR = 0.
  - STOP: StopBits decisions are taken. Any stop sampled 0 sets ferr.
- End of frame, one cycle after the last stop decision tick:
  - Break check comes first. If all data bits, the parity bit (if present) and every stop bit are 0, pulse RxD_break for 1 cycle. No word is delivered and the state goes to BREAK_WAIT.
  - Else if RxD_valid = 0: load RxD_data, perr and ferr, and set RxD_valid.
  - Else, the held word is kept unchanged, the new frame is discarded, and RxD_overrun pulses for 1 cycle.
  - The state returns to IDLE, or BREAK_WAIT as above.
- BREAK_WAIT: stays until the synchronised line has been 1 for Oversampling consecutive ticks, then goes to IDLE. No start detection happens in this state.
- Handshake
  - RxD_valid falls on the cycle after acceptance.
  - If acceptance and a new frame completion fall in the same cycle, the new word loads and RxD_valid stays 1. This is not an overrun.
  - RxD_data, RxD_perr and RxD_ferr are stable while RxD_valid && !RxD_ready.
- Latency: RxD_valid rises 1 clk after the decision tick of the final stop bit.

Test Plan:
Common settings unless stated: ClkFrequency=32000000, Baud=1000000, Oversampling=16, giving Divisor=2 and 32 clk per bit.
1. 8N1, send 0xA5 with RxD_ready=1 -> RxD_valid pulses exactly once with RxD_data=0xA5, perr=0, ferr=0. It rises 1 clk after the stop decision, about 9.5 bit times plus 2 ticks after the start edge.
2. Parity=1 (even), send 0x03 with parity bit 1 -> perr=1 with data 0x03. Repeat with parity bit 0 -> perr=0. Repeat with Parity=2 and bit 0 -> perr=1.
3. Stop bit driven 0 on data 0x5A -> RxD_valid with ferr=1 and data 0x5A. Hold RxD low for 12 bit times -> RxD_break pulse, no RxD_valid. Line returns high for 16 ticks -> the next frame 0x11 is received normally.
4. RxD_ready=0, send 0x12 then 0x34 -> RxD_data stays 0x12 and RxD_overrun pulses once at the end of the second frame. Raise ready -> valid drops and 0x34 is never delivered.
5. 10-clk low glitch in IDLE -> no output and the state returns to IDLE. A 1-sample inverted spike mid data bit is masked by majority, so 0xFF is received as 0xFF.
6. DataBits=5, StopBits=2, send 0x15 -> data 0x15, ferr=0. Assert rst mid-data -> all outputs are 0 immediately. A following frame 0x0A is received correctly.
